// File: rtl/divider_if.sv
// ----------------------------------------------------------------------------
// divider_if : execute-stage <-> divider handshake bundle (ex_div)
//
// Signals
//   flush       EX -> DIV  pipeline flush; aborts an in-flight division
//   div_data1   EX -> DIV  dividend
//   div_data2   EX -> DIV  divisor
//   div_signed  EX -> DIV  1 = two's complement operands, 0 = unsigned
//   div_start   EX -> DIV  request, sampled only while the divider is idle
//   div_result  DIV -> EX  {remainder, quotient}, held until the next start
//   div_done    DIV -> EX  one-cycle strobe, div_result valid from this cycle
//
// Modports: master = execute stage, slave = divider.
// ----------------------------------------------------------------------------
interface divider_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      flush;
   logic [DATA_WIDTH-1:0]     div_data1;
   logic [DATA_WIDTH-1:0]     div_data2;
   logic                      div_signed;
   logic                      div_start;
   logic [2*DATA_WIDTH-1:0]   div_result;
   logic                      div_done;

   modport master (
      output flush,
      output div_data1,
      output div_data2,
      output div_signed,
      output div_start,
      input  div_result,
      input  div_done
   );

   modport slave (
      input  flush,
      input  div_data1,
      input  div_data2,
      input  div_signed,
      input  div_start,
      output div_result,
      output div_done
   );
endinterface

// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider : iterative radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU
//
// Ports
//   clk     system clock
//   rst     asynchronous reset, active-high
//   div_if  divider_if.slave bundle (flush, operands, signed, start in;
//           {remainder, quotient} result and done strobe out)
//
// Operation
//   IDLE : accept a start, turn operands into magnitudes and record the
//          quotient / remainder signs. A zero divisor goes straight to DONE
//          with quotient all-ones and the raw dividend as remainder.
//   BUSY : one quotient bit per cycle, MSB first, DATA_WIDTH cycles.
//   DONE : sign-correct, register the result, strobe div_done, back to IDLE.
//   flush forces IDLE from any state without a done strobe and without
//   touching the held result.
//
// Optional feature (macro DIVIDER_EARLY_TERM_EN)
//   When defined, a nonzero divisor whose magnitude exceeds the dividend
//   magnitude skips BUSY: quotient 0, remainder = original dividend.
//   When undefined those cases take the full iterative path; the result is
//   the same, only latency differs.
// ----------------------------------------------------------------------------
module divider #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   divider_if.slave  div_if
);

   localparam int unsigned DW       = DATA_WIDTH;
   localparam int unsigned CNT_W    = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DW-1:0]       r_rem;      // partial remainder
   logic [DW-1:0]       r_quo;      // dividend shifting out, quotient shifting in
   logic [DW-1:0]       r_dvs;      // divisor magnitude
   logic                r_neg_q;
   logic                r_neg_r;
   logic [2*DW-1:0]     r_result;
   logic                r_done;

   // Operand signs and magnitudes, evaluated on the live inputs in IDLE
   logic                w_sign1;
   logic                w_sign2;
   logic [DW-1:0]       w_mag1;
   logic [DW-1:0]       w_mag2;
   logic                w_div0;
   logic                w_early;

   assign w_sign1 = div_if.div_signed & div_if.div_data1[DW-1];
   assign w_sign2 = div_if.div_signed & div_if.div_data2[DW-1];
   assign w_mag1  = w_sign1 ? DW'(~div_if.div_data1 + DW'(1)) : div_if.div_data1;
   assign w_mag2  = w_sign2 ? DW'(~div_if.div_data2 + DW'(1)) : div_if.div_data2;
   assign w_div0  = (div_if.div_data2 == '0);

`ifdef DIVIDER_EARLY_TERM_EN
   // Quotient is zero and the dividend is already the remainder
   assign w_early = (w_mag2 > w_mag1);
`else
   assign w_early = 1'b0;
`endif

   // One restoring step: shift in the next dividend bit, trial subtract.
   // The extra top bit of the 33-bit difference is the borrow.
   logic [DW:0]         w_shift;
   logic [DW:0]         w_diff;
   logic                w_ge;

   assign w_shift = {r_rem, r_quo[DW-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_ge    = ~w_diff[DW];

   // Sign correction applied on the way out of DONE
   logic [DW-1:0]       w_q_fix;
   logic [DW-1:0]       w_r_fix;

   assign w_q_fix = r_neg_q ? DW'(~r_quo + DW'(1)) : r_quo;
   assign w_r_fix = r_neg_r ? DW'(~r_rem + DW'(1)) : r_rem;

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (div_if.flush) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (div_if.div_start) begin
                     if (w_div0) begin
                        // Raw dividend and all-ones quotient, never corrected
                        r_rem   <= div_if.div_data1;
                        r_quo   <= '1;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_state <= S_DONE;
                     end else if (w_early) begin
                        r_rem   <= div_if.div_data1;
                        r_quo   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_state <= S_DONE;
                     end else begin
                        r_rem   <= '0;
                        r_quo   <= w_mag1;
                        r_dvs   <= w_mag2;
                        r_neg_q <= w_sign1 ^ w_sign2;
                        r_neg_r <= w_sign1;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                     end
                  end
               end

               S_BUSY: begin
                  r_rem <= w_ge ? w_diff[DW-1:0] : w_shift[DW-1:0];
                  r_quo <= {r_quo[DW-2:0], w_ge};
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_CNT) begin
                     r_state <= S_DONE;
                  end
               end

               S_DONE: begin
                  r_result <= {w_r_fix, w_q_fix};
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
               end

               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign div_if.div_result = r_result;
   assign div_if.div_done   = r_done;

endmodule

// File: tb/tb_divider.sv
// ----------------------------------------------------------------------------
// tb_divider : scoreboard bench for divider. Each issued operation pushes its
// hand-computed result and the cycle in which div_done must appear; a monitor
// pops and compares on every div_done.
// ----------------------------------------------------------------------------
module tb_divider;

   localparam int unsigned LAT_FULL = 33;
   localparam int unsigned LAT_ZERO = 1;
`ifdef DIVIDER_EARLY_TERM_EN
   localparam int unsigned LAT_SMALL = 1;
`else
   localparam int unsigned LAT_SMALL = 33;
`endif

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   divider_if #(.DATA_WIDTH(32)) dif ();

   divider #(.DATA_WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (dif.slave)
   );

   typedef struct {
      logic [63:0]  res;
      int unsigned  cyc;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          pushed = 0;
   int          dones_seen = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst === 1'b0 && dif.div_done === 1'b1) begin
         dones_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h with nothing outstanding (cycle %0d)",
                     dif.div_result, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check64("result", dif.div_result, e.res);
            check_int("done_cycle", int'(cyc), int'(e.cyc));
         end
      end
   end

   // Called at a negedge; start is seen at the next posedge, done lat cycles later
   task automatic issue(input logic [31:0] d1, input logic [31:0] d2, input logic sgn,
                        input logic [63:0] exp_res, input int unsigned lat, input bit push);
      dif.div_data1  = d1;
      dif.div_data2  = d2;
      dif.div_signed = sgn;
      dif.div_start  = 1'b1;
      if (push) begin
         sb.push_back('{res: exp_res, cyc: cyc + 1 + lat});
         pushed++;
      end
      @(negedge clk);
      dif.div_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dif.div_done === 1'b1) return;
      end
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no div_done within 40 cycles, required one", name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      dif.flush      = 1'b0;
      dif.div_data1  = '0;
      dif.div_data2  = '0;
      dif.div_signed = 1'b0;
      dif.div_start  = 1'b0;
      repeat (3) @(negedge clk);
      check64("reset_result", dif.div_result, 64'h0);
      check_int("reset_done", int'(dif.div_done), 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic unsigned, then result must hold while idle
      issue(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, LAT_FULL, 1);
      wait_done("u100_7");
      repeat (10) @(negedge clk);
      check64("hold_result", dif.div_result, 64'h00000002_0000000E);

      // Signed -7/2, then the same operands unsigned issued back-to-back
      issue(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, LAT_FULL, 1);
      wait_done("s_m7_2");
      issue(32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, LAT_FULL, 1);
      wait_done("u_m7_2");

      // Signed overflow
      issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, LAT_FULL, 1);
      wait_done("s_ovf");

      // Divide by zero, signed and unsigned, plus a negative dividend
      issue(32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF, LAT_ZERO, 1);
      wait_done("s_5_0");
      issue(32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, LAT_ZERO, 1);
      wait_done("u_5_0");
      issue(32'hFFFFFFFB, 32'd0, 1'b1, 64'hFFFFFFFB_FFFFFFFF, LAT_ZERO, 1);
      wait_done("s_m5_0");

      // Mixed signs and extremes
      issue(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, LAT_FULL, 1);
      wait_done("s_7_m2");
      issue(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, LAT_FULL, 1);
      wait_done("s_m100_m7");
      issue(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, LAT_FULL, 1);
      wait_done("u_max_1");

      // Divisor larger than dividend
      issue(32'd3, 32'd10, 1'b0, 64'h00000003_00000000, LAT_SMALL, 1);
      wait_done("u_3_10");
      issue(32'hFFFFFFFD, 32'd10, 1'b1, 64'hFFFFFFFD_00000000, LAT_SMALL, 1);
      wait_done("s_m3_10");

      // Flush mid-BUSY with a stray start pulse: no done, result untouched
      issue(32'd1000, 32'd3, 1'b0, 64'h0, LAT_FULL, 0);
      repeat (9) @(negedge clk);
      issue(32'd1, 32'd1, 1'b0, 64'h0, LAT_FULL, 0);
      dif.flush = 1'b1;
      @(negedge clk);
      dif.flush = 1'b0;
      repeat (40) @(negedge clk);
      check64("flush_hold", dif.div_result, 64'hFFFFFFFD_00000000);
      issue(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, LAT_FULL, 1);
      wait_done("u_9_3");

      // Flush wins over a simultaneous start
      dif.flush = 1'b1;
      issue(32'd20, 32'd4, 1'b0, 64'h0, LAT_FULL, 0);
      dif.flush = 1'b0;
      repeat (40) @(negedge clk);
      check64("flush_prio_hold", dif.div_result, 64'h00000000_00000003);

      // Reset in the middle of an operation
      issue(32'd50, 32'd5, 1'b0, 64'h0, LAT_FULL, 0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check64("midreset_result", dif.div_result, 64'h0);
      check_int("midreset_done", int'(dif.div_done), 0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue(32'd42, 32'd6, 1'b0, 64'h00000000_00000007, LAT_FULL, 1);
      wait_done("u_42_6");

      repeat (5) @(negedge clk);
      check_int("done_count", dones_seen, pushed);
      check_int("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative radix-2 restoring divider. It is the slave end of the ex_div interface.
- The execute stage issues a start pulse with two operands. The block returns a 64-bit {remainder, quotient} result with a one-cycle done strobe.
- It handles LoongArch DIV.W/DIV.WU/MOD.W/MOD.WU.
- It holds the last result stable until the next accepted start, so EX can stall on it.

Parameters:
- DATA_WIDTH, 32, operand width. Result width is 2*DATA_WIDTH.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- flush  input  1  pipeline flush; aborts an in-flight division
- div_data1  input  32  dividend
- div_data2  input  32  divisor
- div_signed  input  1  1 = signed (two's complement), 0 = unsigned
- div_start  input  1  request; sampled only in IDLE
- div_result  output  64  [63:32] remainder, [31:0] quotient
- div_done  output  1  one-cycle strobe; div_result is valid in this cycle and afterwards

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: state=IDLE, div_result=0, div_done=0, all internal registers 0.
- State IDLE:
  - On div_start=1 and flush=0, latch operands and div_signed.
  - If div_data2==0: go to DONE.
  - Otherwise: convert operands to magnitudes (negate if signed and MSB=1), record quotient sign (sign1^sign2) and remainder sign (sign1), clear the 6-bit counter, go to BUSY.
- State BUSY, one quotient bit per cycle, MSB first:
  - Shift {partial_rem, dividend} left by 1.
  - Trial subtract divisor magnitude in a 33-bit subtractor.
  - If non-negative, keep the difference and set the quotient LSB=1.
  - After the 32nd iteration (counter==31), go to DONE.
- State DONE:
  - Apply sign correction: negate quotient if its sign is set; negate remainder if its sign is set.
  - Register div_result; assert div_done for exactly this cycle; return to IDLE.
- Latency:
  - Normal: div_start sampled at edge N; div_done high in the cycle after edge N+33 (32 BUSY + 1 DONE).
  - Divide by zero: div_done one cycle after the start edge.
- Divide by zero: quotient=0xFFFFFFFF, remainder=dividend (raw, uncorrected), for both signed and unsigned. No exception.
- Signed overflow 0x80000000 / -1: quotient=0x80000000, remainder=0. The magnitude path produces this naturally; no special case.
- Start handling:
  - div_start while BUSY or DONE is ignored. Operands are not re-latched.
  - EX holds div_start until div_done; a start sampled in the cycle that returns to IDLE begins a new operation (back-to-back).
- Flush:
  - flush=1 in any state forces IDLE next cycle; div_done is not asserted; div_result keeps its previous value.
  - Flush has priority over div_start in the same cycle.
- Result hold: div_result changes only on entry to DONE.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: DIVIDER_EARLY_TERM_EN.
- When defined: in IDLE, if divisor magnitude > dividend magnitude (divisor nonzero), skip BUSY and go directly to DONE with quotient=0 and remainder=original dividend (latency 1).
- When undefined: all nonzero divisors take the full 33-cycle path; the result is identical, only timing differs.

Test Plan:
- Unsigned 100/7, start at edge N -> div_done only in cycle N+33; div_result=0x00000002_0000000E; result unchanged 10 cycles later.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> div_result=0xFFFFFFFF_FFFFFFFD. Unsigned same operands -> quotient 0x7FFFFFFC, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> div_result=0x00000000_80000000, no hang.
- 5/0 (signed and unsigned) -> div_done one cycle after start; div_result=0x00000005_FFFFFFFF.
- Start 1000/3, flush 10 cycles later, and pulse div_start during BUSY -> no div_done; next start 9/3 completes with 0x00000000_00000003 at full latency.
- DIVIDER_EARLY_TERM_EN defined: 3/10 -> div_done one cycle after start, div_result=0x00000003_00000000. Undefined: same result at cycle 33.
